// File: rtl/pipe_arb_ctrl_if.sv
// Requester/consumer bundle for pipe_arb_ctrl: two request ports, flush,
// and the stage-N output handshake with occupancy.
interface pipe_arb_ctrl_if #(
    parameter int M = 3,
    parameter int N = 4
);
    logic                     req0;
    logic                     req1;
    logic [M-1:0]             in0;
    logic [M-1:0]             in1;
    logic                     gnt0;
    logic                     gnt1;
    logic                     flush;
    logic                     out_valid;
    logic [M-1:0]             out_data;
    logic                     out_src;
    logic                     out_ready;
    logic [$clog2(N+1)-1:0]   occ;

    modport master (
        output req0, req1, in0, in1, flush, out_ready,
        input  gnt0, gnt1, out_valid, out_data, out_src, occ
    );

    modport slave (
        input  req0, req1, in0, in1, flush, out_ready,
        output gnt0, gnt1, out_valid, out_data, out_src, occ
    );
endinterface

// File: rtl/pipe_arb_ctrl.sv
// Two-requester arbiter feeding an N-stage globally stalled pipeline.
// PIPE_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins) instead of round-robin.
module pipe_arb_ctrl #(
    parameter int M = 3,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_arb_ctrl_if.slave bus
);
    localparam int OCC_W = $clog2(N+1);

    logic [N-1:0]     vld_q, vld_d;
    logic [N-1:0]     src_q, src_d;
    logic [M-1:0]     data_q [N];
    logic [M-1:0]     data_d [N];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             adv;
    logic             gnt0, gnt1;

    function automatic logic [OCC_W-1:0] count_ones(input logic [N-1:0] v);
        logic [OCC_W-1:0] c;
        c = '0;
        for (int k = 0; k < N; k++) c = c + OCC_W'(v[k]);
        return c;
    endfunction

    assign adv = bus.out_ready | ~vld_q[N-1];

`ifdef PIPE_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && adv && !bus.flush) begin
            if (bus.req0)      gnt0 = 1'b1;
            else if (bus.req1) gnt1 = 1'b1;
        end
    end
`else
    typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} state_e;
    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= PRI0;
        else        state_q <= state_d;
    end

    // Grants are gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        if (rst_n && adv && !bus.flush) begin
            if (bus.req0 && (!bus.req1 || state_q == PRI0)) gnt0 = 1'b1;
            else if (bus.req1)                              gnt1 = 1'b1;
        end
        if (gnt0)      state_d = PRI1;
        else if (gnt1) state_d = PRI0;
    end
`endif

    // Flush wins over advance, so a stage-N word offered with out_ready is dropped.
    always_comb begin
        vld_d  = vld_q;
        src_d  = src_q;
        data_d = data_q;
        if (bus.flush) begin
            vld_d = '0;
        end else if (adv) begin
            vld_d[0]  = gnt0 | gnt1;
            src_d[0]  = gnt1;
            data_d[0] = gnt1 ? bus.in1 : (gnt0 ? bus.in0 : '0);
            for (int k = 1; k < N; k++) begin
                vld_d[k]  = vld_q[k-1];
                src_d[k]  = src_q[k-1];
                data_d[k] = data_q[k-1];
            end
        end
        occ_d = count_ones(vld_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            src_q <= '0;
            occ_q <= '0;
            for (int k = 0; k < N; k++) data_q[k] <= '0;
        end else begin
            vld_q  <= vld_d;
            src_q  <= src_d;
            occ_q  <= occ_d;
            data_q <= data_d;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.out_valid = vld_q[N-1];
    assign bus.out_data  = data_q[N-1];
    assign bus.out_src   = src_q[N-1];
    assign bus.occ       = occ_q;
endmodule

// File: tb/tb_pipe_arb_ctrl.sv
// Directed bench for pipe_arb_ctrl: stimulus pushes expected output words,
// a negedge monitor pops and compares every accepted stage-N word.
module tb_pipe_arb_ctrl;
    localparam int M = 3;
    localparam int N = 4;
`ifdef PIPE_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic         src;
        logic [M-1:0] data;
    } word_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    nvec = 0;
    int    nerr = 0;
    word_t sb[$];
    word_t mon_w;

    pipe_arb_ctrl_if #(.M(M), .N(N)) bus ();

    pipe_arb_ctrl #(.M(M), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic [M-1:0] d0,
                         input logic [M-1:0] d1, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        bus.req0      = r0;
        bus.req1      = r1;
        bus.in0       = d0;
        bus.in1       = d1;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic push(input logic s, input logic [M-1:0] d);
        word_t w;
        w.src  = s;
        w.data = d;
        sb.push_back(w);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_word: got src=%0d data=%0d, required no word",
                         bus.out_src, bus.out_data);
            end else begin
                mon_w = sb.pop_front();
                chk("out_src", int'(bus.out_src), int'(mon_w.src));
                chk("out_data", int'(bus.out_data), int'(mon_w.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        logic s;
        bus.req0 = 0; bus.req1 = 0; bus.in0 = '0; bus.in1 = '0;
        bus.out_ready = 1'b1; bus.flush = 1'b0;

        // Reset held with requests pending
        drive(1, 1, 3'd1, 3'd6, 1, 0);
        @(negedge clk);
        chk("reset_gnt0", int'(bus.gnt0), 0);
        chk("reset_gnt1", int'(bus.gnt1), 0);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_occ", int'(bus.occ), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; bus.req0 = 0; bus.req1 = 0;

        // Continuous tie: alternating grants, occ saturates
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 3'd1, 3'd6, 1, 0);
            s = FIXED ? 1'b0 : 1'(i % 2);
            push(s, s ? 3'd6 : 3'd1);
            @(negedge clk);
            chk("tie_gnt0", int'(bus.gnt0), int'(!s));
            chk("tie_gnt1", int'(bus.gnt1), int'(s));
            chk("tie_occ", int'(bus.occ), (i < 4) ? i : 4);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 3'd0, 3'd0, 1, 0);
            @(negedge clk);
        end
        chk("drain_out_valid", int'(bus.out_valid), 0);

        // Single word latency
        drive(1, 0, 3'd5, 3'd0, 1, 0);
        push(1'b0, 3'd5);
        @(negedge clk);
        chk("single_gnt0", int'(bus.gnt0), 1);
        for (int c = 1; c <= 5; c++) begin
            drive(0, 0, 3'd0, 3'd0, 1, 0);
            @(negedge clk);
            if (c == 1) chk("single_occ", int'(bus.occ), 1);
            chk("single_out_valid", int'(bus.out_valid), (c == 4) ? 1 : 0);
        end

        // Fill, stall, release
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 3'(i + 1), 3'd0, 0, 0);
            push(1'b0, 3'(i + 1));
            @(negedge clk);
            chk("fill_gnt0", int'(bus.gnt0), 1);
        end
        for (int h = 0; h < 3; h++) begin
            drive(1, 1, 3'd5, 3'd7, 0, 0);
            @(negedge clk);
            chk("stall_gnt0", int'(bus.gnt0), 0);
            chk("stall_gnt1", int'(bus.gnt1), 0);
            chk("stall_occ", int'(bus.occ), 4);
            chk("stall_out_valid", int'(bus.out_valid), 1);
            chk("stall_out_data", int'(bus.out_data), 1);
        end
        drive(1, 0, 3'd5, 3'd0, 1, 0);
        push(1'b0, 3'd5);
        @(negedge clk);
        chk("release_gnt0", int'(bus.gnt0), 1);
        chk("release_out_data", int'(bus.out_data), 1);
        for (int r = 1; r <= 3; r++) begin
            drive(0, 0, 3'd0, 3'd0, 1, 0);
            @(negedge clk);
            chk("release_out_data", int'(bus.out_data), r + 1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 3'd0, 3'd0, 1, 0);
            @(negedge clk);
        end

        // Flush with occ=3, then state preserved across it
        drive(1, 0, 3'd1, 3'd0, 0, 0);
        push(1'b0, 3'd1);
        @(negedge clk);
        chk("pre_flush_gnt0", int'(bus.gnt0), 1);
        drive(0, 1, 3'd0, 3'd2, 0, 0);
        push(1'b1, 3'd2);
        @(negedge clk);
        chk("pre_flush_gnt1", int'(bus.gnt1), 1);
        drive(1, 0, 3'd3, 3'd0, 0, 0);
        push(1'b0, 3'd3);
        @(negedge clk);
        chk("pre_flush_gnt0", int'(bus.gnt0), 1);
        drive(1, 0, 3'd4, 3'd0, 1, 1);
        sb.delete();
        @(negedge clk);
        chk("flush_occ_before", int'(bus.occ), 3);
        chk("flush_gnt0", int'(bus.gnt0), 0);
        chk("flush_gnt1", int'(bus.gnt1), 0);
        drive(0, 0, 3'd0, 3'd0, 1, 0);
        @(negedge clk);
        chk("post_flush_occ", int'(bus.occ), 0);
        chk("post_flush_out_valid", int'(bus.out_valid), 0);
        drive(1, 1, 3'd2, 3'd7, 1, 0);
        s = FIXED ? 1'b0 : 1'b1;
        push(s, s ? 3'd7 : 3'd2);
        @(negedge clk);
        chk("post_flush_tie_gnt1", int'(bus.gnt1), int'(s));
        chk("post_flush_tie_gnt0", int'(bus.gnt0), int'(!s));
        drive(1, 1, 3'd2, 3'd7, 1, 0);
        push(1'b0, 3'd2);
        @(negedge clk);
        chk("post_flush_tie2_gnt0", int'(bus.gnt0), 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 3'd0, 3'd0, 1, 0);
            @(negedge clk);
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 3'(i + 1), 3'd0, 1, 0);
            push(1'b0, 3'(i + 1));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req0 = 0;
        #1;
        chk("pre_reset_occ", int'(bus.occ), 3);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_reset_occ", int'(bus.occ), 0);
        chk("async_reset_out_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 1, 3'd4, 3'd3, 1, 0);
        push(1'b0, 3'd4);
        @(negedge clk);
        chk("post_reset_tie_gnt0", int'(bus.gnt0), 1);
        drive(1, 1, 3'd4, 3'd3, 1, 0);
        s = FIXED ? 1'b0 : 1'b1;
        push(s, s ? 3'd3 : 3'd4);
        @(negedge clk);
        chk("post_reset_tie2_gnt1", int'(bus.gnt1), int'(s));
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 3'd0, 3'd0, 1, 0);
            @(negedge clk);
        end
        chk("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
